// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and helpers for the UART transmitter.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    // Ceiling log2 for values up to 2**30.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered FULL/EMPTY; pushes while full are rejected.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_reject
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_d;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // FULL is the registered flag, so a push in the same cycle as a pop is still refused.
    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;
    assign o_reject  = i_push && r_full;

    always_comb begin
        w_count_d = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_d;
            r_full  <= (w_count_d == FULL_CNT);
            r_empty <= (w_count_d == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with configurable width, parity and stop bits.
// RST asserts asynchronously; its release is expected to be synchronous to CLK_50MHZ.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 CLK_50MHZ,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 TRG_WRITE,
    input  logic                 FLOW,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 OVERFLOW
);

    localparam int unsigned BW = clog2(BAUD_DIV);
    localparam int unsigned NW = clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

    tx_state_e            r_state;
    tx_state_e            w_state_d;
    logic [BW-1:0]        r_baud;
    logic [BW-1:0]        w_baud_d;
    logic [NW-1:0]        r_bit;
    logic [NW-1:0]        w_bit_d;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_d;
    logic                 r_par;
    logic                 w_par_d;
    logic                 r_tx;
    logic                 w_tx_d;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_done_d;
    logic                 r_overflow;
    logic                 w_baud_last;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_reject;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK_50MHZ),
        .i_rst_n (RST),
        .i_push  (TRG_WRITE),
        .i_wdata (DATA_IN),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_reject(w_reject)
    );

    assign w_baud_last = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_bit_d   = r_bit;
        w_par_d   = r_par;
        w_pop     = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty && FLOW) begin
                    w_pop     = 1'b1;
                    w_shift_d = w_fifo_data;
                    w_bit_d   = '0;
                    w_par_d   = (PARITY == PAR_EVEN) ? ^w_fifo_data : ~^w_fifo_data;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_baud_last) begin
                    w_state_d = StData;
                end
            end
            StData: begin
                if (w_baud_last) begin
                    w_shift_d = r_shift >> 1;
                    if (r_bit == DATA_LAST) begin
                        w_bit_d   = '0;
                        w_state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        w_bit_d = r_bit + NW'(1);
                    end
                end
            end
            StParity: begin
                if (w_baud_last) begin
                    w_bit_d   = '0;
                    w_state_d = StStop;
                end
            end
            StStop: begin
                if (w_baud_last) begin
                    if (r_bit == STOP_LAST) begin
                        w_state_d = StIdle;
                    end else begin
                        w_bit_d = r_bit + NW'(1);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        if (w_state_d != r_state || r_state == StIdle || w_baud_last) begin
            w_baud_d = '0;
        end else begin
            w_baud_d = r_baud + BW'(1);
        end

        w_tx_d = 1'b1;
        case (w_state_d)
            StStart:  w_tx_d = 1'b0;
            StData:   w_tx_d = w_shift_d[0];
            StParity: w_tx_d = w_par_d;
            default:  w_tx_d = 1'b1;
        endcase

        w_done_d = (w_state_d == StStop) && (w_baud_d == BAUD_LAST) && (w_bit_d == STOP_LAST);
    end

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_state    <= StIdle;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_baud     <= w_baud_d;
            r_bit      <= w_bit_d;
            r_shift    <= w_shift_d;
            r_par      <= w_par_d;
            r_tx       <= w_tx_d;
            r_busy     <= (w_state_d != StIdle);
            r_done     <= w_done_d;
            r_overflow <= r_overflow | w_reject;
        end
    end

    assign TX       = r_tx;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign FULL     = w_full;
    assign EMPTY    = w_empty;
    assign OVERFLOW = r_overflow;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synthesizable, parametrised UART transmitter with an internal write FIFO. It is the next generation of the TX half of the UART used by the RS232 front end.
- Generalised data width, parity and stop-bit count.
- Buffered multi-byte writes.
- FLOW (CTS-style) gating at frame start.
- Per-frame DONE pulse.
It sits between host logic that issues TRG_WRITE strobes and the RS232 TX pin.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9).
BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); minimum 2.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame (1 or 2).
FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2.

Ports:
CLK_50MHZ  input  1  main clock; all logic on rising edge.
RST  input  1  reset, asynchronous assert, active-low (0 = reset); synchronous release.
DATA_IN  input  DATA_BITS  word to enqueue.
TRG_WRITE  input  1  push strobe; one word per high cycle.
FLOW  input  1  1 = peer ready; sampled only at frame start.
TX  output  1  serial line, idle high.
BUSY  output  1  frame in progress.
DONE  output  1  one-cycle pulse at end of each frame.
FULL  output  1  FIFO full.
EMPTY  output  1  FIFO empty.
OVERFLOW  output  1  sticky; set by a push while FULL; cleared only by reset.

Behaviour:
- Reset state (RST=0): TX=1, BUSY=0, DONE=0, FULL=0, EMPTY=1, OVERFLOW=0; FIFO pointers and count zeroed; FSM in IDLE. Applies asynchronously, including mid-frame; the frame is dropped and TX returns high immediately.
- FIFO push: TRG_WRITE=1 and FULL=0 -> DATA_IN stored at write pointer. TRG_WRITE=1 and FULL=1 -> word discarded, OVERFLOW set.
- FIFO pop: the FSM pops on the IDLE->START transition.
- Simultaneous push and pop: both occur and the count is unchanged. A push while FULL in the same cycle as a pop is still rejected, because FULL is evaluated before the pop.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1. FULL and EMPTY are registered and derived from the next-state count.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX=1, BUSY=0. When EMPTY=0 and FLOW=1: pop, load shift register, clear bit counter, go to START.
- START: TX=0 for BAUD_DIV cycles, then DATA.
- DATA: TX = shift[0] (LSB first). Each bit lasts BAUD_DIV cycles. After DATA_BITS bits, go to PARITY if PARITY != 0, else STOP.
- PARITY: TX = ^data for even, ~^data for odd; lasts BAUD_DIV cycles.
- STOP: TX=1 for STOP_BITS*BAUD_DIV cycles. DONE=1 on the last cycle of STOP, then go to IDLE.
- Back-to-back frames: the next frame may start on the cycle after DONE, giving a one-cycle idle gap.
- TX, BUSY and DONE are registered. TX first goes low on the cycle after the pop.
- BUSY is 1 from the START entry cycle through the DONE cycle inclusive.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles.
- FLOW falling mid-frame does not abort the frame. A low FLOW only holds off the next frame.
- Baud counter counts 0..BAUD_DIV-1 and resets on every state change. Its width is clog2(BAUD_DIV).

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - FSM state encoding;
  - a clog2 function.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), contains storage, pointers, FULL/EMPTY and the reject-on-full rule.
- uart_tx_fifo contains the FSM, baud counter, shift register and OVERFLOW flag.

Test Plan:
1. Basic frame, BAUD_DIV=4, 8N1: push 8'h03 with FLOW=1 -> TX low 4 cycles, then bits 1,1,0,0,0,0,0,0 at 4 cycles each, then high 4 cycles; DONE pulses exactly 40 cycles after the first TX-low cycle minus 1; EMPTY=1 afterwards.
2. Burst with parity, 8E2: push 8'h03 then 8'h06 in consecutive cycles -> two frames with parity bits 0 and 0, each 12 bits long, separated by one idle cycle; two DONE pulses.
3. Odd parity: send 8'h07 with PARITY=1 -> parity bit 0; send 8'h06 -> parity bit 1.
4. FIFO full, FIFO_DEPTH=4: hold FLOW=0 and push 5 words -> FULL=1 after the 4th push, OVERFLOW=1 after the 5th. Raise FLOW -> exactly 4 frames in push order; FULL drops on the first pop.
5. Flow gating: FLOW=0 with data queued -> TX stays 1 and BUSY stays 0 indefinitely. Lower FLOW mid-frame -> the current frame completes and the next does not start until FLOW=1.
6. Reset mid-frame: assert RST=0 during DATA bit 3 -> TX=1, BUSY=0, EMPTY=1 and OVERFLOW=0 immediately, without waiting for a clock edge. After release, no residual frame appears.
